// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receiver: RX state encoding, frame constants
// and the start-edge helper.
package uart_rx_pkg;

    typedef logic bit_t;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE_RX  = 2'd0,
        START_RX = 2'd1,
        DATA_RX  = 2'd2,
        STOP_RX  = 2'd3
    } rx_state_t;

    function automatic bit_t start_edge(input bit_t prev_s, input bit_t cur_s);
        return prev_s & ~cur_s;
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// Control FSM of the UART receiver: sequences START/DATA/STOP and issues
// timer-clear, shift, counter and load strobes to the datapath.
module uart_rx_fsm
    import uart_rx_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_line_s,
    input  logic i_start_edge,
    input  logic i_last_bit,
    output logic o_timer_clr,
    output logic o_cnt_clr,
    output logic o_shift_en,
    output logic o_load,
    output logic o_half,
    output logic o_busy
);

    rx_state_t r_state;
    logic      r_busy;

    // State sequencing; busy is tracked alongside so it leaves the block registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE_RX;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE_RX: begin
                    if (i_start_edge) begin
                        r_state <= START_RX;
                        r_busy  <= 1'b1;
                    end
                end
                START_RX: begin
                    if (i_tick) begin
                        if (!i_line_s) begin
                            r_state <= DATA_RX;
                        end else begin
                            r_state <= IDLE_RX;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DATA_RX: begin
                    if (i_tick && i_last_bit) begin
                        r_state <= STOP_RX;
                    end
                end
                STOP_RX: begin
                    if (i_tick) begin
                        r_state <= IDLE_RX;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE_RX;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Strobes must coincide with the tick, so they are decoded from state and tick.
    always_comb begin
        o_timer_clr = i_tick;
        o_cnt_clr   = 1'b0;
        o_shift_en  = 1'b0;
        o_load      = 1'b0;
        o_half      = 1'b0;
        case (r_state)
            IDLE_RX: begin
                o_timer_clr = 1'b1;
                o_cnt_clr   = 1'b1;
            end
            START_RX: o_half     = 1'b1;
            DATA_RX:  o_shift_en = i_tick;
            STOP_RX:  o_load     = i_tick;
            default: begin
                o_timer_clr = 1'b1;
                o_cnt_clr   = 1'b1;
            end
        endcase
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling timer, bit counter,
// shift register and a flag/clear handshake with sticky error flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = DATA_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  clear_flag,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_flag,
    output logic                  framing_error,
    output logic                  overrun_error,
    output logic                  busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] HALF_TGT = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_TGT = TW'(CLKS_PER_BIT - 1);

    logic                  r_sync;
    logic                  r_line_s;
    logic                  r_line_d;
    logic [TW-1:0]         r_timer;
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_flag;
    logic                  r_ferr;
    logic                  r_oerr;

    logic w_tick, w_last_bit, w_start_edge;
    logic w_timer_clr, w_cnt_clr, w_shift_en, w_load, w_half, w_busy;

    assign w_tick       = (r_timer == (w_half ? HALF_TGT : FULL_TGT));
    assign w_last_bit   = (r_bit_cnt == CW'(DATA_WIDTH - 1));
    assign w_start_edge = start_edge(r_line_d, r_line_s);

    uart_rx_fsm u_fsm (
        .clk          (clk),
        .reset        (reset),
        .i_tick       (w_tick),
        .i_line_s     (r_line_s),
        .i_start_edge (w_start_edge),
        .i_last_bit   (w_last_bit),
        .o_timer_clr  (w_timer_clr),
        .o_cnt_clr    (w_cnt_clr),
        .o_shift_en   (w_shift_en),
        .o_load       (w_load),
        .o_half       (w_half),
        .o_busy       (w_busy)
    );

    // Two-flop synchronizer plus delayed copy for start-edge detection; idle level is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync   <= 1'b1;
            r_line_s <= 1'b1;
            r_line_d <= 1'b1;
        end else begin
            r_sync   <= serial_in;
            r_line_s <= r_sync;
            r_line_d <= r_line_s;
        end
    end

    // Bit timer and bit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer   <= {TW{1'b0}};
            r_bit_cnt <= {CW{1'b0}};
        end else begin
            r_timer <= w_timer_clr ? {TW{1'b0}} : r_timer + TW'(1);
            if (w_cnt_clr) begin
                r_bit_cnt <= {CW{1'b0}};
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
        end
    end

    // LSB-first frame: shifting in at the MSB leaves bit 0 at the bottom after the last bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= {DATA_WIDTH{1'b0}};
        end else if (w_shift_en) begin
            r_shift <= {r_line_s, r_shift[DATA_WIDTH-1:1]};
        end
    end

    // Output handshake: a completing frame beats a simultaneous clear, but the clear
    // still wipes older errors and suppresses overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data <= {DATA_WIDTH{1'b0}};
            r_rx_flag <= 1'b0;
            r_ferr    <= 1'b0;
            r_oerr    <= 1'b0;
        end else if (w_load) begin
            r_rx_data <= r_shift;
            r_rx_flag <= 1'b1;
            r_ferr    <= ~r_line_s | (r_ferr & ~clear_flag);
            r_oerr    <= (r_rx_flag | r_oerr) & ~clear_flag;
        end else if (clear_flag) begin
            r_rx_flag <= 1'b0;
            r_ferr    <= 1'b0;
            r_oerr    <= 1'b0;
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_flag       = r_rx_flag;
    assign framing_error = r_ferr;
    assign overrun_error = r_oerr;
    assign busy          = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-serially, the expected
// byte, flags and arrival cycle are queued, and a monitor checks them on arrival.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DW  = 8;
    // serial_in -> line_s takes 2 edges; flag appears 153 cycles after line_s falls
    localparam int FLAG_LAT = 2 + CPB / 2 + (DW + 1) * CPB + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          serial_in;
    logic          clear_flag;
    logic [DW-1:0] rx_data;
    logic          rx_flag, framing_error, overrun_error, busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .clear_flag    (clear_flag),
        .rx_data       (rx_data),
        .rx_flag       (rx_flag),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
        logic          ferr;
        logic          oerr;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   total = 0;
    int   bad   = 0;
    logic m_flag = 1'b0, m_ferr = 1'b0, m_oerr = 1'b0;
    logic m_data_valid_zero = 1'b1;
    logic prev_flag = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a frame must complete exactly at its due cycle; any other rise is spurious.
    always @(negedge clk) begin
        if (sb.size() > 0 && cyc == sb[0].due) begin
            e_mon = sb.pop_front();
            check("flag_rise", {31'd0, rx_flag}, 32'd1);
            check("rx_data", {24'd0, rx_data}, {24'd0, e_mon.data});
            check("framing_error", {31'd0, framing_error}, {31'd0, e_mon.ferr});
            check("overrun_error", {31'd0, overrun_error}, {31'd0, e_mon.oerr});
        end else if (rx_flag && !prev_flag) begin
            total++;
            bad++;
            $display("FAIL spurious_flag: got rx_flag=1 expected 0 (cycle %0d)", cyc);
        end
        prev_flag <= rx_flag;
    end

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_low, input logic clr_at_stop);
        logic [9:0]  bits;
        exp_t        e;
        int          bc;
        bits   = {~stop_low, d, 1'b0};
        e.due  = cyc + FLAG_LAT;
        e.data = d;
        e.ferr = stop_low | (m_ferr & ~clr_at_stop);
        e.oerr = (m_flag | m_oerr) & ~clr_at_stop;
        sb.push_back(e);
        m_flag = 1'b1;
        m_ferr = e.ferr;
        m_oerr = e.oerr;
        bc = 0;
        for (int c = 0; c < 10 * CPB; c++) begin
            if (busy) bc++;
            serial_in  = bits[c / CPB];
            clear_flag = clr_at_stop && (c == FLAG_LAT - 1);
            @(negedge clk);
        end
        clear_flag = 1'b0;
        check("busy_len", bc, (DW + 1) * CPB + CPB / 2);
    endtask

    task automatic do_clear();
        clear_flag = 1'b1;
        @(negedge clk);
        clear_flag = 1'b0;
        m_flag = 1'b0;
        m_ferr = 1'b0;
        m_oerr = 1'b0;
        check("clr_flag", {31'd0, rx_flag}, {31'd0, m_flag});
        check("clr_ferr", {31'd0, framing_error}, {31'd0, m_ferr});
        check("clr_oerr", {31'd0, overrun_error}, {31'd0, m_oerr});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc;
        logic [7:0]  a, b;
        int unsigned mode;

        reset = 1'b0; serial_in = 1'b1; clear_flag = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_flag", {31'd0, rx_flag}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_ferr", {31'd0, framing_error}, 32'd0);
        check("rst_oerr", {31'd0, overrun_error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        idle(5);

        // nominal frame
        send_frame(8'hA5, 1'b0, 1'b0);
        idle(4);
        do_clear();

        // short glitch: start sample sees high again
        bc = 0;
        serial_in = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 5) serial_in = 1'b1;
            @(negedge clk);
            if (busy) bc++;
        end
        check("glitch_busy", bc, CPB / 2);
        check("glitch_flag", {31'd0, rx_flag}, {31'd0, m_flag});

        // framing error, then a line stuck low, then recovery
        send_frame(8'h3C, 1'b1, 1'b0);
        serial_in = 1'b0;
        repeat (100) @(negedge clk);
        check("low_busy", {31'd0, busy}, 32'd0);
        check("low_flag", {31'd0, rx_flag}, {31'd0, m_flag});
        idle(20);
        send_frame(8'h01, 1'b0, 1'b0);
        do_clear();

        // back-to-back overrun
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        do_clear();

        // clear coincides with the stop tick of the second frame
        send_frame(8'h33, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b1);
        do_clear();

        // reset in the middle of the 4th data bit of 0xFF
        for (int c = 0; c < 4 * CPB + CPB / 2; c++) begin
            serial_in = (c < CPB) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        reset = 1'b1;
        m_flag = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
        idle(20 * CPB);
        check("abort_flag", {31'd0, rx_flag}, 32'd0);
        check("abort_data", {24'd0, rx_data}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0);
        do_clear();

        // randomized traffic
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                send_frame(a, 1'b0, 1'b0);
                idle($urandom_range(0, 20));
            end else if (mode == 1) begin
                send_frame(a, 1'b0, 1'b0);
                send_frame(b, 1'b0, 1'b0);
            end else begin
                send_frame(a, 1'b1, 1'b0);
                serial_in = 1'b0;
                repeat (30) @(negedge clk);
                idle(10);
            end
            do_clear();
        end

        for (int w = 0; w < 400 && sb.size() > 0; w++) @(negedge clk);
        check("sb_drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
